// File: rtl/alu_control_seq.sv
// ALU control stage: registers the decode function code, routes it to the owning
// execution unit and sequences the multi-cycle MULTU with busy/done handshake.
module alu_control_seq #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Signal,
    output logic [5:0] SignaltoALU,
    output logic [5:0] SignaltoSHT,
    output logic [5:0] SignaltoMUL,
    output logic [5:0] SignaltoMUX,
    output logic       busy,
    output logic       done
);

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLL   = 6'b000010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] CNT_LAST = 6'(MUL_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t     state_r;
    logic [5:0] cnt_r;
    logic [5:0] alu_r;
    logic [5:0] sht_r;
    logic [5:0] mul_r;
    logic [5:0] mux_r;
    logic       busy_r;
    logic       done_r;

    // Control FSM: decode in IDLE, count out the multiply in MUL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
            alu_r   <= 6'd0;
            sht_r   <= 6'd0;
            mul_r   <= 6'd0;
            mux_r   <= 6'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r  <= 6'd0;
                    alu_r  <= 6'd0;
                    sht_r  <= 6'd0;
                    mul_r  <= 6'd0;
                    mux_r  <= 6'd0;
                    busy_r <= 1'b0;
                    case (Signal)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                            alu_r <= Signal;
                            mux_r <= Signal;
                        end
                        OP_SLL: begin
                            sht_r <= OP_SLL;
                            mux_r <= OP_SLL;
                        end
                        OP_MFHI, OP_MFLO: begin
                            mux_r <= Signal;
                        end
                        OP_MULTU: begin
                            state_r <= ST_MUL;
                            mul_r   <= OP_MULTU;
                            mux_r   <= OP_MULTU;
                            busy_r  <= 1'b1;
                        end
                        default: begin
                            mux_r <= 6'd0;
                        end
                    endcase
                end
                ST_MUL: begin
                    // The last count edge both ends the multiply and raises done.
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 6'd0;
                        mul_r   <= 6'd0;
                        mux_r   <= 6'd0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 6'd0;
                    alu_r   <= 6'd0;
                    sht_r   <= 6'd0;
                    mul_r   <= 6'd0;
                    mux_r   <= 6'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign SignaltoALU = alu_r;
    assign SignaltoSHT = sht_r;
    assign SignaltoMUL = mul_r;
    assign SignaltoMUX = mux_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: default and MUL_CYCLES=4 instances
// compared every cycle against a countdown-based behavioural model.
module tb_alu_control_seq;

    localparam logic [5:0] MULTU = 6'b011001;

    typedef struct {
        logic [5:0] alu;
        logic [5:0] sht;
        logic [5:0] mul;
        logic [5:0] mux;
        logic       busy;
        logic       done;
        int         mul_left;
    } model_t;

    logic       clk;
    logic       reset;
    logic [5:0] sig_a;
    logic [5:0] sig_b;
    logic [5:0] alu_a, sht_a, mul_a, mux_a;
    logic [5:0] alu_b, sht_b, mul_b, mux_b;
    logic       busy_a, done_a, busy_b, done_b;
    model_t     ma;
    model_t     mb;
    int         errors;
    int         checks;

    wire [25:0] obs_a = {alu_a, sht_a, mul_a, mux_a, busy_a, done_a};
    wire [25:0] obs_b = {alu_b, sht_b, mul_b, mux_b, busy_b, done_b};

    alu_control_seq dut_a (
        .clk(clk), .reset(reset), .Signal(sig_a),
        .SignaltoALU(alu_a), .SignaltoSHT(sht_a), .SignaltoMUL(mul_a),
        .SignaltoMUX(mux_a), .busy(busy_a), .done(done_a)
    );

    alu_control_seq #(.MUL_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .Signal(sig_b),
        .SignaltoALU(alu_b), .SignaltoSHT(sht_b), .SignaltoMUL(mul_b),
        .SignaltoMUX(mux_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t model_zero();
        model_t z;
        z.alu = 6'd0; z.sht = 6'd0; z.mul = 6'd0; z.mux = 6'd0;
        z.busy = 1'b0; z.done = 1'b0; z.mul_left = 0;
        return z;
    endfunction

    // One clock edge of the architectural behaviour: a multiply is a countdown of
    // remaining busy cycles; otherwise the code is classified and routed.
    function automatic model_t model_step(model_t m, logic [5:0] s, int mc);
        model_t n;
        n = model_zero();
        if (m.mul_left > 0) begin
            n = m;
            n.mul_left = m.mul_left - 1;
            if (n.mul_left == 0) begin
                n = model_zero();
                n.done = 1'b1;
            end
        end else if (s inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
            n.alu = s; n.mux = s;
        end else if (s == 6'b000010) begin
            n.sht = s; n.mux = s;
        end else if (s == 6'b010000 || s == 6'b010010) begin
            n.mux = s;
        end else if (s == MULTU) begin
            n.mul = s; n.mux = s; n.busy = 1'b1; n.mul_left = mc;
        end
        return n;
    endfunction

    function automatic logic [25:0] pack(model_t m);
        return {m.alu, m.sht, m.mul, m.mux, m.busy, m.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        ma = model_step(ma, sig_a, 32);
        mb = model_step(mb, sig_b, 4);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        sig_a = 6'd0;
        sig_b = 6'd0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sig_a = 6'd0;
        sig_b = 6'd0;
        ma = model_zero();
        mb = model_zero();
        #12;
        checks++;
        if (obs_a !== 26'd0) begin
            errors++; $display("FAIL reset_a: got %h expected %h", obs_a, 26'd0);
        end
        checks++;
        if (obs_b !== 26'd0) begin
            errors++; $display("FAIL reset_b: got %h expected %h", obs_b, 26'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sll_then_add();
        sig_a = 6'b000010;
        tick();
        checks++;
        if (sht_a !== 6'b000010 || mux_a !== 6'b000010 || alu_a !== 6'd0) begin
            errors++; $display("FAIL sll_first: got sht=%b mux=%b alu=%b expected 000010 000010 000000", sht_a, mux_a, alu_a);
        end
        sig_a = 6'b100000;
        tick();
        checks++;
        if (alu_a !== 6'b100000 || sht_a !== 6'd0 || mux_a !== 6'b100000) begin
            errors++; $display("FAIL add_second: got alu=%b sht=%b mux=%b expected 100000 000000 100000", alu_a, sht_a, mux_a);
        end
        checks++;
        if (obs_a !== pack(ma)) begin
            errors++; $display("FAIL add_model: got %h expected %h", obs_a, pack(ma));
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 64; i++) begin
            sig_a = 6'(i);
            sig_b = (i == 25) ? 6'd0 : 6'(i);
            tick();
            checks++;
            if (obs_a !== pack(ma)) begin
                errors++; $display("FAIL sweep_a code=%b: got %h expected %h", 6'(i), obs_a, pack(ma));
            end
            if (ma.mul_left > 0) drain(33);
        end
    endtask

    task automatic test_multu();
        int busy_cnt;
        int done_cnt;
        int done_at;
        drain(3);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        sig_a = MULTU;
        tick();
        sig_a = 6'b100010;
        if (busy_a) busy_cnt++;
        for (int t = 1; t < 36; t++) begin
            tick();
            checks++;
            if (obs_a !== pack(ma)) begin
                errors++; $display("FAIL multu_cycle%0d: got %h expected %h", t, obs_a, pack(ma));
            end
            if (busy_a && mul_a === MULTU) busy_cnt++;
            if (done_a) begin done_cnt++; done_at = t; end
        end
        checks++;
        if (busy_cnt !== 32) begin
            errors++; $display("FAIL multu_busy_len: got %0d expected 32", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 32) begin
            errors++; $display("FAIL multu_done: got count=%0d at=%0d expected 1 at 32", done_cnt, done_at);
        end
        checks++;
        if (alu_a !== 6'b100010) begin
            errors++; $display("FAIL multu_after_sub: got %b expected 100010", alu_a);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        int done_cnt;
        drain(3);
        busy_cnt = 0; done_cnt = 0;
        sig_a = MULTU;
        for (int t = 0; t < 66; t++) begin
            tick();
            checks++;
            if (obs_a !== pack(ma)) begin
                errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", t, obs_a, pack(ma));
            end
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            if (t == 32 && busy_a !== 1'b0) begin
                errors++; $display("FAIL b2b_gap: got busy=%b expected 0", busy_a);
            end
        end
        checks++;
        if (busy_cnt !== 64 || done_cnt !== 2) begin
            errors++; $display("FAIL b2b_totals: got busy=%0d done=%0d expected 64 and 2", busy_cnt, done_cnt);
        end
        drain(2);
    endtask

    task automatic test_reset_mid_mul();
        int done_seen;
        done_seen = 0;
        sig_a = MULTU;
        tick();
        sig_a = 6'd0;
        for (int t = 0; t < 10; t++) tick();
        #2;
        reset = 1'b0;
        #1;
        ma = model_zero();
        mb = model_zero();
        checks++;
        if (obs_a !== 26'd0 || obs_b !== 26'd0) begin
            errors++; $display("FAIL reset_mid_mul: got a=%h b=%h expected 0 0", obs_a, obs_b);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (done_a) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", done_seen);
        end
        sig_a = 6'b010000;
        tick();
        checks++;
        if (mux_a !== 6'b010000 || obs_a !== pack(ma)) begin
            errors++; $display("FAIL mfhi_after_reset: got mux=%b expected 010000", mux_a);
        end
    endtask

    task automatic test_short_mul();
        int busy_cnt;
        int done_at;
        drain(6);
        busy_cnt = 0; done_at = -1;
        sig_b = MULTU;
        for (int t = 0; t < 7; t++) begin
            tick();
            sig_b = 6'd0;
            checks++;
            if (obs_b !== pack(mb)) begin
                errors++; $display("FAIL short_cycle%0d: got %h expected %h", t, obs_b, pack(mb));
            end
            if (busy_b) busy_cnt++;
            if (done_b) done_at = t;
        end
        checks++;
        if (busy_cnt !== 4 || done_at !== 4) begin
            errors++; $display("FAIL short_mul: got busy=%0d done_at=%0d expected 4 and 4", busy_cnt, done_at);
        end
    endtask

    task automatic test_random();
        logic [5:0] known [9];
        known = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                  6'b000010, 6'b011001, 6'b010000, 6'b010010};
        for (int t = 0; t < 300; t++) begin
            sig_a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known[$urandom_range(0, 8)];
            sig_b = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known[$urandom_range(0, 8)];
            tick();
            // Mid-cycle input glitches must not reach the registered outputs.
            #1;
            sig_a = 6'($urandom);
            sig_b = 6'($urandom);
            checks++;
            if (obs_a !== pack(ma) || obs_b !== pack(mb)) begin
                errors++; $display("FAIL random_cycle%0d: got a=%h b=%h expected a=%h b=%h", t, obs_a, obs_b, pack(ma), pack(mb));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sll_then_add();
        test_sweep();
        test_multu();
        test_back_to_back();
        test_reset_mid_mul();
        test_short_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
